// File: rtl/datapath_seq_ctrl.sv
// ---------------------------------------------------------------------------
// datapath_seq_ctrl
//   Multi-cycle sequencer for a simple register-file/ALU datapath. An
//   instruction is accepted in WAIT, decoded, and then walked through
//   operand fetch, execute and write-back states. All outputs are Moore
//   outputs: they depend only on the current state and on the latched
//   instruction fields.
//
// Parameters
//   RN_W        width of register-index fields and of readnum/writenum (2..5)
//   ERR_STICKY  0: err is a one-cycle pulse in ERR
//               1: err stays high in WAIT until the next accepted s
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low reset
//   s                        start, sampled only in WAIT
//   opcode[2:0], op[1:0]     instruction class / sub-op
//   rn, rd, rm [RN_W-1:0]    register indices
//   sh[1:0]                  shift code for operand B
//   w                        idle/ready (WAIT)
//   err                      illegal-instruction flag
//   loada, loadb, loadc, loads, asel, bsel, vsel, write
//                            datapath strobes/selects (vsel 1 = immediate)
//   shift[1:0]               shifter control
//   readnum, writenum        register-file addresses
// ---------------------------------------------------------------------------
module datapath_seq_ctrl #(
  parameter int RN_W       = 3,
  parameter int ERR_STICKY = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s,
  input  logic [2:0]      opcode,
  input  logic [1:0]      op,
  input  logic [RN_W-1:0] rn,
  input  logic [RN_W-1:0] rd,
  input  logic [RN_W-1:0] rm,
  input  logic [1:0]      sh,
  output logic            w,
  output logic            err,
  output logic            loada,
  output logic            loadb,
  output logic            loadc,
  output logic            loads,
  output logic            asel,
  output logic            bsel,
  output logic            vsel,
  output logic            write,
  output logic [1:0]      shift,
  output logic [RN_W-1:0] readnum,
  output logic [RN_W-1:0] writenum
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_C,
    S_WR_IMM,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [2:0]      r_opcode;
  logic [1:0]      r_op;
  logic [1:0]      r_sh;
  logic [RN_W-1:0] r_rn;
  logic [RN_W-1:0] r_rd;
  logic [RN_W-1:0] r_rm;
  logic            r_err_hold;

  logic            w_accept;
  logic            w_movi;
  logic            w_mov;
  logic            w_mvn;
  logic            w_add;
  logic            w_and;
  logic            w_cmp;
  logic            w_two_op;
  logic            w_one_op;

  assign w_accept = (r_state == S_WAIT) && s;

  // Instruction class decoded from the latched fields only.
  assign w_movi   = (r_opcode == 3'b110) && (r_op == 2'b10);
  assign w_mov    = (r_opcode == 3'b110) && (r_op == 2'b00);
  assign w_add    = (r_opcode == 3'b101) && (r_op == 2'b00);
  assign w_cmp    = (r_opcode == 3'b101) && (r_op == 2'b01);
  assign w_and    = (r_opcode == 3'b101) && (r_op == 2'b10);
  assign w_mvn    = (r_opcode == 3'b101) && (r_op == 2'b11);
  assign w_two_op = w_add || w_and || w_cmp;
  assign w_one_op = w_mov || w_mvn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_WAIT;
      r_opcode   <= '0;
      r_op       <= '0;
      r_sh       <= '0;
      r_rn       <= '0;
      r_rd       <= '0;
      r_rm       <= '0;
      r_err_hold <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_opcode <= opcode;
        r_op     <= op;
        r_sh     <= sh;
        r_rn     <= rn;
        r_rd     <= rd;
        r_rm     <= rm;
      end
      // Remembers that the last instruction was illegal; only observable
      // on err when the sticky variant is selected.
      if (w_accept) begin
        r_err_hold <= 1'b0;
      end else if (r_state == S_ERR) begin
        r_err_hold <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:   w_next = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (w_movi) begin
          w_next = S_WR_IMM;
        end else if (w_one_op) begin
          w_next = S_GET_B;
        end else if (w_two_op) begin
          w_next = S_GET_A;
        end else begin
          w_next = S_ERR;
        end
      end
      S_GET_A:  w_next = S_GET_B;
      S_GET_B:  w_next = S_EXEC;
      S_EXEC:   w_next = w_cmp ? S_WAIT : S_WR_C;
      S_WR_C:   w_next = S_WAIT;
      S_WR_IMM: w_next = S_WAIT;
      S_ERR:    w_next = S_WAIT;
      default:  w_next = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    err      = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 1'b0;
    write    = 1'b0;
    shift    = '0;
    readnum  = '0;
    writenum = '0;
    case (r_state)
      S_WAIT: begin
        w   = 1'b1;
        err = (ERR_STICKY != 0) && r_err_hold;
      end
      S_GET_A: begin
        loada   = 1'b1;
        readnum = r_rn;
      end
      S_GET_B: begin
        loadb   = 1'b1;
        readnum = r_rm;
      end
      S_EXEC: begin
        shift = r_sh;
        // MOV/MVN have no A operand, so A is forced to zero.
        asel  = w_one_op;
        loadc = !w_cmp;
        loads = w_cmp;
      end
      S_WR_C: begin
        write    = 1'b1;
        vsel     = 1'b0;
        writenum = r_rd;
      end
      S_WR_IMM: begin
        write    = 1'b1;
        vsel     = 1'b1;
        writenum = r_rn;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        w = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_datapath_seq_ctrl
//   Drives two instances in lock-step from one stimulus stream:
//     A: RN_W=3, ERR_STICKY=0 (indices use the low 3 bits)
//     B: RN_W=4, ERR_STICKY=1
//   Expected outputs per cycle come from an instruction-level timeline model.
// ---------------------------------------------------------------------------
module tb_datapath_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s = 1'b0;
  logic [2:0] opcode = '0;
  logic [1:0] op = '0;
  logic [1:0] sh = '0;
  logic [3:0] rn = '0;
  logic [3:0] rd = '0;
  logic [3:0] rm = '0;

  logic       w_a, err_a, la_a, lb_a, lc_a, ls_a, asel_a, bsel_a, vsel_a, wr_a;
  logic [1:0] shift_a;
  logic [2:0] rnum_a, wnum_a;
  logic       w_b, err_b, la_b, lb_b, lc_b, ls_b, asel_b, bsel_b, vsel_b, wr_b;
  logic [1:0] shift_b;
  logic [3:0] rnum_b, wnum_b;

  datapath_seq_ctrl #(.RN_W(3), .ERR_STICKY(0)) u_dut_a (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .rn(rn[2:0]), .rd(rd[2:0]), .rm(rm[2:0]), .sh(sh),
    .w(w_a), .err(err_a), .loada(la_a), .loadb(lb_a), .loadc(lc_a),
    .loads(ls_a), .asel(asel_a), .bsel(bsel_a), .vsel(vsel_a), .write(wr_a),
    .shift(shift_a), .readnum(rnum_a), .writenum(wnum_a)
  );

  datapath_seq_ctrl #(.RN_W(4), .ERR_STICKY(1)) u_dut_b (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .rn(rn), .rd(rd), .rm(rm), .sh(sh),
    .w(w_b), .err(err_b), .loada(la_b), .loadb(lb_b), .loadc(lc_b),
    .loads(ls_b), .asel(asel_b), .bsel(bsel_b), .vsel(vsel_b), .write(wr_b),
    .shift(shift_b), .readnum(rnum_b), .writenum(wnum_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic       err;
    logic       la;
    logic       lb;
    logic       lc;
    logic       ls;
    logic       asel;
    logic       bsel;
    logic       vsel;
    logic       wr;
    logic [1:0] shift;
    logic [4:0] rnum;
    logic [4:0] wnum;
  } obs_t;

  typedef enum {K_MOVI, K_MOV, K_MVN, K_ADD, K_AND, K_CMP, K_ILL} kind_t;

  int    checks = 0;
  int    failures = 0;
  kind_t k = K_ILL;
  int    lat = 3;
  logic [3:0] c_rn = '0, c_rd = '0, c_rm = '0;
  logic [1:0] c_sh = '0;
  bit    hold_b = 1'b0;

  function automatic kind_t classify(input logic [2:0] opc, input logic [1:0] o);
    if (opc == 3'b110 && o == 2'b10) return K_MOVI;
    if (opc == 3'b110 && o == 2'b00) return K_MOV;
    if (opc == 3'b101 && o == 2'b00) return K_ADD;
    if (opc == 3'b101 && o == 2'b10) return K_AND;
    if (opc == 3'b101 && o == 2'b01) return K_CMP;
    if (opc == 3'b101 && o == 2'b11) return K_MVN;
    return K_ILL;
  endfunction

  // Cycles from the accept edge until w returns to 1.
  function automatic int latency(input kind_t kk);
    case (kk)
      K_MOVI:       return 3;
      K_MOV, K_MVN: return 5;
      K_CMP:        return 5;
      K_ADD, K_AND: return 6;
      default:      return 3;
    endcase
  endfunction

  // Expected outputs t cycles after the accept edge (t=0 or t>=lat: idle).
  // Cycle 1 is always decode; operands follow, then execute, then write-back.
  function automatic obs_t expect_at(input int t, input int l, input kind_t kk,
                                     input logic [3:0] xrn, input logic [3:0] xrd,
                                     input logic [3:0] xrm, input logic [1:0] xsh,
                                     input logic [3:0] mask, input bit hold);
    obs_t e;
    bit   two;
    int   bcyc;
    int   xcyc;
    e = '0;
    if (t <= 0 || t >= l) begin
      e.w   = 1'b1;
      e.err = hold;
      return e;
    end
    two  = (kk == K_ADD) || (kk == K_AND) || (kk == K_CMP);
    bcyc = two ? 3 : 2;
    xcyc = bcyc + 1;
    if (kk == K_MOVI) begin
      if (t == 2) begin
        e.wr   = 1'b1;
        e.vsel = 1'b1;
        e.wnum = {1'b0, xrn & mask};
      end
    end else if (kk == K_ILL) begin
      if (t == 2) e.err = 1'b1;
    end else begin
      if (two && t == 2) begin
        e.la   = 1'b1;
        e.rnum = {1'b0, xrn & mask};
      end
      if (t == bcyc) begin
        e.lb   = 1'b1;
        e.rnum = {1'b0, xrm & mask};
      end
      if (t == xcyc) begin
        e.shift = xsh;
        e.lc    = (kk != K_CMP);
        e.ls    = (kk == K_CMP);
        e.asel  = !two;
      end
      if (t == xcyc + 1 && kk != K_CMP) begin
        e.wr   = 1'b1;
        e.wnum = {1'b0, xrd & mask};
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input int t);
    obs_t oa, ob, ea, eb;
    bit   hb;
    oa = '{w: w_a, err: err_a, la: la_a, lb: lb_a, lc: lc_a, ls: ls_a,
           asel: asel_a, bsel: bsel_a, vsel: vsel_a, wr: wr_a, shift: shift_a,
           rnum: {2'b00, rnum_a}, wnum: {2'b00, wnum_a}};
    ob = '{w: w_b, err: err_b, la: la_b, lb: lb_b, lc: lc_b, ls: ls_b,
           asel: asel_b, bsel: bsel_b, vsel: vsel_b, wr: wr_b, shift: shift_b,
           rnum: {1'b0, rnum_b}, wnum: {1'b0, wnum_b}};
    hb = (t == 0) ? hold_b : (k == K_ILL);
    ea = expect_at(t, lat, k, c_rn, c_rd, c_rm, c_sh, 4'h7, 1'b0);
    eb = expect_at(t, lat, k, c_rn, c_rd, c_rm, c_sh, 4'hF, hb);
    checks++;
    assert (oa === ea) else begin
      failures++;
      $error("FAIL %s_A t=%0d kind=%s observed=%h expected=%h", tag, t, k.name(), oa, ea);
    end
    checks++;
    assert (ob === eb) else begin
      failures++;
      $error("FAIL %s_B t=%0d kind=%s observed=%h expected=%h", tag, t, k.name(), ob, eb);
    end
  endtask

  task automatic scramble();
    opcode = 3'($urandom);
    op     = 2'($urandom);
    sh     = 2'($urandom);
    rn     = 4'($urandom);
    rd     = 4'($urandom);
    rm     = 4'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", 0);
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one instruction in WAIT and follows it to completion. Fields
  // are scrambled and s toggled randomly while busy; both must be ignored.
  // reset_at > 0 drops reset asynchronously inside that cycle instead.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                           input logic [3:0] xrn, input logic [3:0] xrd,
                           input logic [3:0] xrm, input logic [1:0] xsh,
                           input int reset_at);
    opcode = opc; op = o; rn = xrn; rd = xrd; rm = xrm; sh = xsh;
    s = 1'b1;
    @(posedge clk);
    #1;
    k = classify(opc, o); lat = latency(k);
    c_rn = xrn; c_rd = xrd; c_rm = xrm; c_sh = xsh;
    hold_b = 1'b0;
    s = 1'b0;
    scramble();
    for (int t = 1; t <= lat; t++) begin
      if (t == reset_at) begin
        s = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        hold_b = 1'b0;
        check("reset_async", 0);
        @(negedge clk);
        check("reset_held", 0);
        return;
      end
      @(negedge clk);
      check("run", t);
      @(posedge clk);
      #1;
      scramble();
      s = (t + 1 < lat) ? 1'($urandom) : 1'b0;
    end
    hold_b = (k == K_ILL);
  endtask

  initial begin
    logic [2:0] ropc;
    int         r;
    #1;
    check("reset_state", 0);
    @(negedge clk);
    check("reset_state", 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(1);

    run_instr(3'b110, 2'b10, 4'd5, 4'd0, 4'd0, 2'b00, 0);   // MOVI rn=5
    run_instr(3'b101, 2'b00, 4'd1, 4'd3, 4'd2, 2'b01, 0);   // ADD
    run_instr(3'b101, 2'b01, 4'd4, 4'd0, 4'd4, 2'b10, 0);   // CMP
    run_instr(3'b111, 2'b00, 4'd1, 4'd2, 4'd3, 2'b11, 0);   // illegal
    idle(3);
    run_instr(3'b110, 2'b10, 4'd15, 4'd0, 4'd0, 2'b00, 0);  // MOVI clears held err
    run_instr(3'b101, 2'b11, 4'd0, 4'd14, 4'd15, 2'b10, 0); // MVN rm=15 rd=14
    run_instr(3'b110, 2'b00, 4'd7, 4'd8, 4'd9, 2'b01, 0);   // MOV
    run_instr(3'b101, 2'b10, 4'd15, 4'd0, 4'd8, 2'b11, 0);  // AND

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 3));
      ropc = (r == 0) ? 3'b110 : (r == 3) ? 3'($urandom) : 3'b101;
      run_instr(ropc, 2'($urandom), 4'($urandom), 4'($urandom),
                4'($urandom), 2'($urandom), 0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // Illegal leaves B's err high; reset mid-ADD must clear it and abort.
    run_instr(3'b000, 2'b01, 4'd0, 4'd0, 4'd0, 2'b00, 0);
    idle(1);
    run_instr(3'b101, 2'b00, 4'd6, 4'd7, 4'd5, 2'b01, 3);
    reset = 1'b1;
    // s already high with these fields on the first edge after release.
    run_instr(3'b110, 2'b10, 4'd9, 4'd0, 4'd0, 2'b00, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_seq_ctrl.md
DATAPATH_SEQ_CTRL -- requirements
Module: datapath_seq_ctrl

Interface
REQ-001 SHALL have parameter RN_W, default 3, width of each register-index field and of readnum/writenum; legal range 2..5.
REQ-002 SHALL have parameter ERR_STICKY, default 0: 0 = err is a one-cycle pulse; 1 = err is held until the next accepted s or reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s, input, 1 bit: start; sampled only in WAIT.
REQ-006 SHALL have port opcode, input, 3 bits: instruction class.
REQ-007 SHALL have port op, input, 2 bits: ALU/move sub-op.
REQ-008 SHALL have ports rn, rd, rm, input, RN_W bits each: register indices.
REQ-009 SHALL have port sh, input, 2 bits: shift code for operand B.
REQ-010 SHALL have port w, output, 1 bit: idle/ready.
REQ-011 SHALL have port err, output, 1 bit: illegal-instruction flag.
REQ-012 SHALL have ports loada, loadb, loadc, loads, asel, bsel, vsel, write, output, 1 bit each: datapath strobes and selects; vsel 1 = immediate, 0 = C.
REQ-013 SHALL have port shift, output, 2 bits: shifter control.
REQ-014 SHALL have ports readnum and writenum, output, RN_W bits each: register-file addresses.

Function
REQ-015 SHALL have Moore outputs decoded from state and the latched fields only; no input reaches an output combinationally.
REQ-016 SHALL, in WAIT with s=1, latch opcode, op, rn, rd, rm and sh, and go to DECODE; s outside WAIT SHALL be ignored.
REQ-017 SHALL route DECODE by latched fields: 110/10 MOVI -> WR_IMM; 110/00 MOV -> GET_B; 101/00 ADD and 101/10 AND -> GET_A; 101/01 CMP -> GET_A; 101/11 MVN -> GET_B; all other combinations -> ERR.
REQ-018 SHALL sequence the states as: GET_A -> GET_B -> EXEC (ADD, AND, CMP); GET_B -> EXEC (MOV, MVN); EXEC -> WR_C, except CMP, where EXEC -> WAIT; WR_C, WR_IMM and ERR -> WAIT.
REQ-019 SHALL drive w=1 only in WAIT.
REQ-020 SHALL drive, in GET_A: loada=1, readnum=rn.
REQ-021 SHALL drive, in GET_B: loadb=1, readnum=rm.
REQ-022 SHALL drive, in EXEC: shift=sh; asel=1 for MOV/MVN (A forced to zero); loadc=1 except CMP; loads=1 only for CMP.
REQ-023 SHALL drive, in WR_C: write=1, vsel=0, writenum=rd.
REQ-024 SHALL drive, in WR_IMM: write=1, vsel=1, writenum=rn.
REQ-025 SHALL drive every output not named for the current state to 0, including shift=00, readnum=0 and writenum=0.
REQ-026 SHALL pulse err=1 in ERR; with ERR_STICKY=1, err stays 1 through WAIT and clears on the next accepted s.
REQ-027 SHALL have latency, counted from the s-accept edge to w=1: MOVI 3 cycles, MOV/MVN 5, CMP 5, ADD/AND 6, illegal 3.
REQ-028 SHALL pass RN_W-bit indices unmodified, so any index 0..2^RN_W-1 is legal and no wrap or truncation occurs.
REQ-029 SHALL keep write asserted for exactly one cycle per write-back instruction and never for CMP or an illegal instruction.

Reset
REQ-030 SHALL, on reset low at any time including mid-instruction, enter WAIT immediately, abandon the instruction, clear latched fields and err, and hold every output at 0 except w=1.
REQ-031 SHALL leave WAIT no earlier than the first rising edge after reset deasserts; s present on that edge SHALL be accepted.

Verification
REQ-032 SHALL cover: RN_W=3, MOVI rn=5 -> write=1 and vsel=1 with writenum=5 exactly 2 cycles after accept; w=1 at cycle 3.
REQ-033 SHALL cover: ADD rn=1, rm=2, rd=3, sh=01 -> readnum 1 then 2; shift=01 with loadc=1 at cycle 4; write with writenum=3 at cycle 5; w at cycle 6.
REQ-034 SHALL cover: CMP rn=4, rm=4 -> loads=1 in EXEC, write and loadc never asserted, w at cycle 5.
REQ-035 SHALL cover: opcode=111 -> err=1 for one cycle (ERR_STICKY=0), no strobes; with ERR_STICKY=1, err holds until the next s.
REQ-036 SHALL cover: reset low during GET_B of ADD, and s pulsed while busy -> immediate WAIT, all strobes 0; the busy s produces no extra instruction.
REQ-037 SHALL cover: RN_W=4, MVN rm=15, rd=14 -> readnum=15, asel=1 in EXEC, writenum=14.
